hazard_flush_ctrl: RTL

//  Pipeline sequencer for the IF/ID boundary of the RV32 core. Owns the flush input of the
//  ID-stage instruction decode mux and the stall/bubble enables of PC, IF/ID and ID/EX.

---
 rtl/hazard_flush_ctrl_if.sv | 35 +++
 rtl/hazard_flush_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hazard_flush_ctrl_if.sv
// IF/ID hazard sequencer bundle: hazard/redirect/imem inputs in, flush/stall enables and debug counters out.
// master drives the pipeline-side inputs, slave is the sequencer.
interface hazard_flush_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1_addr_in;
  logic [4:0]       id_rs2_addr_in;
  logic             id_uses_rs1_in;
  logic             id_uses_rs2_in;
  logic [4:0]       ex_rd_addr_in;
  logic             ex_mem_read_in;
  logic             redirect_in;
  logic             imem_ready_in;
  logic             flush_o;
  logic             pc_stall_o;
  logic             ifid_stall_o;
  logic             idex_bubble_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_rs1_addr_in, id_rs2_addr_in, id_uses_rs1_in, id_uses_rs2_in,
    output ex_rd_addr_in, ex_mem_read_in, redirect_in, imem_ready_in,
    input  flush_o, pc_stall_o, ifid_stall_o, idex_bubble_o,
    input  state_o, flush_cnt_o, stall_cnt_o
  );

  modport slave (
    input  id_rs1_addr_in, id_rs2_addr_in, id_uses_rs1_in, id_uses_rs2_in,
    input  ex_rd_addr_in, ex_mem_read_in, redirect_in, imem_ready_in,
    output flush_o, pc_stall_o, ifid_stall_o, idex_bubble_o,
    output state_o, flush_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// IF/ID sequencer: redirect flush, load-use stall+bubble, imem wait; outputs are zero-latency from state+inputs.
// Backpressure: holds PC (and IF/ID on load-use) while stalled; saturating debug counters of flush/stall events.
module hazard_flush_ctrl #(
  parameter int FLUSH_CYCLES    = 2,
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  hazard_flush_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_STALL  = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_IMEM_WAIT = 2'd3
  } state_e;

  localparam int MAXC = (FLUSH_CYCLES > LU_STALL_CYCLES) ? FLUSH_CYCLES : LU_STALL_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] LU_LOAD    = CW'(LU_STALL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_hz;
  logic flush, pc_stall, ifid_stall, idex_bubble;
  logic stall_inc;

  assign lu_hz = bus.ex_mem_read_in && (bus.ex_rd_addr_in != 5'd0) &&
                 ((bus.id_uses_rs1_in && (bus.id_rs1_addr_in == bus.ex_rd_addr_in)) ||
                  (bus.id_uses_rs2_in && (bus.id_rs2_addr_in == bus.ex_rd_addr_in)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush       = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;

    if (bus.redirect_in) begin
      // A redirect wins from every state, including a reload while already flushing.
      flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_LOAD;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (lu_hz) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              state_d = ST_LU_STALL;
              cnt_d   = LU_LOAD;
            end
          end else if (!bus.imem_ready_in) begin
            pc_stall = 1'b1;
            flush    = 1'b1;
            state_d  = ST_IMEM_WAIT;
          end
        end
        ST_LU_STALL: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_FLUSH: begin
          // ID already holds a NOP here, so a load-use match is not a real hazard.
          flush = 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_d = bus.imem_ready_in ? ST_RUN : ST_IMEM_WAIT;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          if (bus.imem_ready_in) begin
            state_d = ST_RUN;
          end else begin
            pc_stall = 1'b1;
            flush    = 1'b1;
          end
        end
      endcase
    end
  end

  assign stall_inc = (pc_stall && !flush) || (state_q == ST_IMEM_WAIT);

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.redirect_in && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
    if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset forces the decode mux to NOP and releases every stall.
  assign bus.flush_o       = !rst_in || flush;
  assign bus.pc_stall_o    = rst_in && pc_stall;
  assign bus.ifid_stall_o  = rst_in && ifid_stall;
  assign bus.idex_bubble_o = rst_in && idex_bubble;
  assign bus.state_o       = state_q;
  assign bus.flush_cnt_o   = flush_cnt_q;
  assign bus.stall_cnt_o   = stall_cnt_q;

endmodule
